// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle for alu_mul_sequencer.
// slave: the sequencer side; master: the issuing pipeline side.
interface alu_mul_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [DATA_W-1:0] multiplicand_i;
  logic [DATA_W-1:0] multiplier_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] product_o;
  logic              abort_i;

  modport slave (
    input  req_valid_i, multiplicand_i, multiplier_i, rsp_ready_i, abort_i,
    output req_ready_o, rsp_valid_o, product_o
  );

  modport master (
    output req_valid_i, multiplicand_i, multiplier_i, rsp_ready_i, abort_i,
    input  req_ready_o, rsp_valid_o, product_o
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 low-half multiplier that borrows the shared ALU for its adds.
// Optional macro MUL_EARLY_EXIT_EN: leave RUN once the remaining multiplier bits are zero.
module alu_mul_sequencer #(
  parameter int          DATA_W     = 32,
  parameter logic [3:0]  ALU_ADD_OP = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  alu_mul_sequencer_if.slave bus,
  output logic              alu_owner_o,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_bit;

`ifdef MUL_EARLY_EXIT_EN
  assign last_bit = (count_q == LAST) || ((mplier_q >> 1) == '0);
`else
  assign last_bit = (count_q == LAST);
`endif

  assign alu_op_o        = ALU_ADD_OP;
  assign alu_a_o         = acc_q;
  assign alu_b_o         = mcand_q;
  assign alu_owner_o     = (state_q == RUN);
  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.product_o   = (state_q == RESP) ? acc_q : '0;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        // abort blocks acceptance even though ready stays asserted
        if (bus.req_valid_i && !bus.abort_i) begin
          acc_d    = '0;
          mcand_d  = bus.multiplicand_i;
          mplier_d = bus.multiplier_i;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = alu_result_i;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (bus.abort_i)   state_d = IDLE;
        else if (last_bit) state_d = RESP;
      end
      RESP: begin
        if (bus.abort_i || bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer; the ALU is modelled here as a plain adder.
module tb_alu_mul_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_owner;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  int          tests = 0;
  int          failed = 0;

  alu_mul_sequencer_if #(.DATA_W(32)) bus ();

  alu_mul_sequencer #(.DATA_W(32), .ALU_ADD_OP(4'b0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .alu_owner_o  (alu_owner),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result)
  );

  assign alu_result = (alu_op == 4'b0000) ? alu_a + alu_b : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_run(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int r = 1;
    for (int i = 0; i < 32; i++) if (b[i]) r = i + 1;
    return r;
`else
    return 32;
`endif
  endfunction

  // Caller is at a negedge with the DUT idle; returns at a negedge back in IDLE.
  task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int hold);
    int run = 0;
    bit got = 1'b0;
    check({tag, "_ready_pre"}, bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1; bus.multiplicand_i = a; bus.multiplier_i = b;
    @(posedge clk); #1 bus.req_valid_i = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (alu_owner) begin
        if (run == 0) check({tag, "_alu_b_first"}, alu_b, a);
        run++;
      end
      if (bus.rsp_valid_o) got = 1'b1;
    end
    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_run_len"}, run, exp_run(b));
    check({tag, "_product"}, bus.product_o, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.rsp_valid_o, 1);
      check({tag, "_hold_product"}, bus.product_o, exp);
      check({tag, "_hold_ready"}, bus.req_ready_o, 0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, bus.rsp_valid_o, 0);
    check({tag, "_post_ready"}, bus.req_ready_o, 1);
  endtask

  // Starts an operation and returns at the negedge of RUN cycle n.
  task automatic start_and_run(input logic [31:0] a, input logic [31:0] b, input int n);
    bus.req_valid_i = 1'b1; bus.multiplicand_i = a; bus.multiplier_i = b;
    @(posedge clk); #1 bus.req_valid_i = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0; bus.abort_i = 1'b0;
    bus.multiplicand_i = '0; bus.multiplier_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready_o, 1);
    check("rst_valid", bus.rsp_valid_o, 0);
    check("rst_product", bus.product_o, 0);
    check("rst_owner", alu_owner, 0);
    check("rst_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    reset = 1'b1;
    @(negedge clk);

    mul("m7x6", 32'd7, 32'd6, 32'd42, 0);
    mul("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    mul("mwrap", 32'h8000_0000, 32'd2, 32'h0000_0000, 0);
    mul("mhold", 32'h1234_5678, 32'h10, 32'h2345_6780, 5);
    mul("m100x5", 32'd100, 32'd5, 32'd500, 0);

    // abort in RUN cycle 10
    start_and_run(32'd9, 32'h8000_0007, 10);
    check("abort_owner_pre", alu_owner, 1);
    bus.abort_i = 1'b1;
    @(posedge clk); #1 bus.abort_i = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.req_ready_o, 1);
    check("abort_owner", alu_owner, 0);
    check("abort_valid", bus.rsp_valid_o, 0);
    @(negedge clk);
    check("abort_valid_late", bus.rsp_valid_o, 0);
    mul("m3x5", 32'd3, 32'd5, 32'd15, 0);

    // reset in RUN cycle 10
    start_and_run(32'd9, 32'h8000_0007, 10);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("mrst_ready", bus.req_ready_o, 1);
    check("mrst_valid", bus.rsp_valid_o, 0);
    check("mrst_product", bus.product_o, 0);
    check("mrst_owner", alu_owner, 0);
    check("mrst_alu_a", alu_a, 0);
    check("mrst_alu_b", alu_b, 0);

    // abort and request together in IDLE
    bus.abort_i = 1'b1; bus.req_valid_i = 1'b1;
    bus.multiplicand_i = 32'd4; bus.multiplier_i = 32'd4;
    @(posedge clk); #1 begin bus.abort_i = 1'b0; bus.req_valid_i = 1'b0; end
    @(negedge clk);
    check("idle_abort_owner", alu_owner, 0);
    check("idle_abort_ready", bus.req_ready_o, 1);
    check("idle_abort_alu_b", alu_b, 0);
    @(negedge clk);
    check("idle_abort_valid", bus.rsp_valid_o, 0);

    mul("m9x0", 32'd9, 32'd0, 32'd0, 0);
    mul("m1xmsb", 32'd1, 32'h8000_0000, 32'h8000_0000, 0);

    // abort and rsp_ready together in RESP: response dropped
    start_and_run(32'd2, 32'd3, exp_run(32'd3) + 1);
    check("ra_valid_pre", bus.rsp_valid_o, 1);
    check("ra_product_pre", bus.product_o, 6);
    bus.abort_i = 1'b1; bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1 begin bus.abort_i = 1'b0; bus.rsp_ready_i = 1'b0; end
    @(negedge clk);
    check("ra_valid", bus.rsp_valid_o, 0);
    check("ra_ready", bus.req_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
